// File: rtl/rv32_mem_arbiter.sv
// Single-port memory arbiter for an RV32I core: fetch (I) and load/store (D) share one
// memory port, one transaction in flight, D-priority with a bounded D streak and a response timeout.
module rv32_mem_arbiter #(
    parameter int XLEN         = 32,
    parameter int MAX_D_STREAK = 4,
    parameter int TIMEOUT      = 16,
    parameter int TW           = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_req,
    input  logic [XLEN-1:0] i_addr,
    output logic            i_done,
    output logic [XLEN-1:0] i_rdata,
    input  logic            d_req,
    input  logic            d_we,
    input  logic [XLEN-1:0] d_addr,
    input  logic [XLEN-1:0] d_wdata,
    input  logic [3:0]      d_wstrb,
    output logic            d_done,
    output logic [XLEN-1:0] d_rdata,
    output logic            err,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    output logic [3:0]      mem_wstrb,
    input  logic            mem_gnt,
    input  logic            mem_rvalid,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            busy,
    output logic            owner
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int SW = $clog2(MAX_D_STREAK + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);
    localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT - 1);

    state_t            state_reg,     state_next;
    logic [SW-1:0]     streak_reg,    streak_next;
    logic [TW-1:0]     tmo_reg,       tmo_next;
    logic              mem_req_reg,   mem_req_next;
    logic              mem_we_reg,    mem_we_next;
    logic [XLEN-1:0]   mem_addr_reg,  mem_addr_next;
    logic [XLEN-1:0]   mem_wdata_reg, mem_wdata_next;
    logic [3:0]        mem_wstrb_reg, mem_wstrb_next;
    logic              i_done_reg,    i_done_next;
    logic              d_done_reg,    d_done_next;
    logic              err_reg,       err_next;
    logic [XLEN-1:0]   i_rdata_reg,   i_rdata_next;
    logic [XLEN-1:0]   d_rdata_reg,   d_rdata_next;
    logic              busy_reg,      busy_next;
    logic              owner_reg,     owner_next;

    logic              resp_ok;
    logic              resp_tmo;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            streak_reg    <= '0;
            tmo_reg       <= '0;
            mem_req_reg   <= 1'b0;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
            mem_wstrb_reg <= 4'h0;
            i_done_reg    <= 1'b0;
            d_done_reg    <= 1'b0;
            err_reg       <= 1'b0;
            i_rdata_reg   <= '0;
            d_rdata_reg   <= '0;
            busy_reg      <= 1'b0;
            owner_reg     <= 1'b0;
        end else begin
            state_reg     <= state_next;
            streak_reg    <= streak_next;
            tmo_reg       <= tmo_next;
            mem_req_reg   <= mem_req_next;
            mem_we_reg    <= mem_we_next;
            mem_addr_reg  <= mem_addr_next;
            mem_wdata_reg <= mem_wdata_next;
            mem_wstrb_reg <= mem_wstrb_next;
            i_done_reg    <= i_done_next;
            d_done_reg    <= d_done_next;
            err_reg       <= err_next;
            i_rdata_reg   <= i_rdata_next;
            d_rdata_reg   <= d_rdata_next;
            busy_reg      <= busy_next;
            owner_reg     <= owner_next;
        end
    end

    // A response completes the transaction; otherwise the timeout may fire on the same edge,
    // in which case the real response takes precedence.
    always_comb begin
        resp_ok  = 1'b0;
        resp_tmo = 1'b0;
        if (state_reg == REQ) begin
            resp_ok = mem_gnt && mem_rvalid;
        end else if (state_reg == RESP) begin
            resp_ok = mem_rvalid;
        end
        if ((state_reg == REQ) || (state_reg == RESP)) begin
            resp_tmo = (TIMEOUT != 0) && (tmo_reg == TMO_LAST) && !resp_ok;
        end
    end

    always_comb begin
        state_next     = state_reg;
        streak_next    = streak_reg;
        tmo_next       = tmo_reg;
        mem_req_next   = mem_req_reg;
        mem_we_next    = mem_we_reg;
        mem_addr_next  = mem_addr_reg;
        mem_wdata_next = mem_wdata_reg;
        mem_wstrb_next = mem_wstrb_reg;
        i_done_next    = 1'b0;
        d_done_next    = 1'b0;
        err_next       = 1'b0;
        i_rdata_next   = i_rdata_reg;
        d_rdata_next   = d_rdata_reg;
        owner_next     = owner_reg;

        case (state_reg)
            IDLE: begin
                if (i_req || d_req) begin
                    state_next   = REQ;
                    mem_req_next = 1'b1;
                    tmo_next     = '0;
                    if (i_req && (!d_req || (streak_reg == STREAK_MAX))) begin
                        owner_next     = 1'b0;
                        mem_we_next    = 1'b0;
                        mem_addr_next  = i_addr;
                        mem_wdata_next = '0;
                        mem_wstrb_next = 4'h0;
                        streak_next    = '0;
                    end else begin
                        owner_next     = 1'b1;
                        mem_we_next    = d_we;
                        mem_addr_next  = d_addr;
                        mem_wdata_next = d_wdata;
                        mem_wstrb_next = d_we ? d_wstrb : 4'h0;
                        // The streak only matters while a fetch is actually waiting.
                        if (!i_req) begin
                            streak_next = '0;
                        end else if (streak_reg != STREAK_MAX) begin
                            streak_next = streak_reg + 1'b1;
                        end
                    end
                end
            end

            REQ, RESP: begin
                tmo_next = tmo_reg + 1'b1;
                if (resp_ok) begin
                    state_next   = DONE;
                    mem_req_next = 1'b0;
                    if (!owner_reg) begin
                        i_done_next  = 1'b1;
                        i_rdata_next = mem_rdata;
                    end else begin
                        d_done_next = 1'b1;
                        if (!mem_we_reg) begin
                            d_rdata_next = mem_rdata;
                        end
                    end
                end else if (resp_tmo) begin
                    state_next   = DONE;
                    mem_req_next = 1'b0;
                    err_next     = 1'b1;
                    if (!owner_reg) begin
                        i_done_next  = 1'b1;
                        i_rdata_next = '0;
                    end else begin
                        d_done_next  = 1'b1;
                        d_rdata_next = '0;
                    end
                end else if ((state_reg == REQ) && mem_gnt) begin
                    state_next   = RESP;
                    mem_req_next = 1'b0;
                end
            end

            DONE: begin
                state_next = IDLE;
            end

            default: begin
                state_next   = IDLE;
                mem_req_next = 1'b0;
            end
        endcase

        busy_next = (state_next != IDLE);
    end

    assign i_done    = i_done_reg;
    assign i_rdata   = i_rdata_reg;
    assign d_done    = d_done_reg;
    assign d_rdata   = d_rdata_reg;
    assign err       = err_reg;
    assign mem_req   = mem_req_reg;
    assign mem_we    = mem_we_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;
    assign mem_wstrb = mem_wstrb_reg;
    assign busy      = busy_reg;
    assign owner     = owner_reg;

endmodule

// File: tb/tb_rv32_mem_arbiter.sv
// Directed bench for rv32_mem_arbiter: fetch, store, load, zero-wait, contention,
// timeout race, timeout with late response, and reset in the middle of a response wait.
module tb_rv32_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_done;
    logic [31:0] i_rdata;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_wstrb;
    logic        d_done;
    logic [31:0] d_rdata;
    logic        err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        busy;
    logic        owner;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [31:0] seen_addr;
    logic [31:0] seen_wdata;
    logic        seen_we;
    logic [3:0]  seen_wstrb;
    logic        seen_owner;

    rv32_mem_arbiter #(
        .XLEN(32), .MAX_D_STREAK(4), .TIMEOUT(16), .TW(8)
    ) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_done(i_done), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
        .d_done(d_done), .d_rdata(d_rdata), .err(err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .busy(busy), .owner(owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wait_mem_req();
        int k = 0;
        while (mem_req !== 1'b1 && k < 10) begin
            tick();
            k++;
        end
        check("mem_req_seen", 32'(mem_req), 32'd1);
    endtask

    // Serves one memory transaction: grant on request, response lat cycles later (0 = same cycle).
    // Returns at the negedge of the DONE cycle.
    task automatic do_txn(input int lat, input logic [31:0] rdata);
        wait_mem_req();
        seen_addr  = mem_addr;
        seen_wdata = mem_wdata;
        seen_we    = mem_we;
        seen_wstrb = mem_wstrb;
        seen_owner = owner;
        mem_gnt = 1'b1;
        if (lat == 0) begin
            mem_rvalid = 1'b1;
            mem_rdata  = rdata;
        end
        tick();
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        if (lat > 0) begin
            check("req_one_cycle", 32'(mem_req), 32'd0);
            repeat (lat - 1) tick();
            mem_rvalid = 1'b1;
            mem_rdata  = rdata;
            tick();
            mem_rvalid = 1'b0;
        end
        $display("txn owner=%0d we=%0d addr=0x%08h wstrb=0x%0h i_done=%0d d_done=%0d err=%0d",
                 seen_owner, seen_we, seen_addr, seen_wstrb, i_done, d_done, err);
    endtask

    initial begin
        int t0;
        int t1;
        logic exp_owner;

        rst = 1'b1;
        i_req = 1'b0; i_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_wstrb = 4'h0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        repeat (3) tick();
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_owner", 32'(owner), 32'd0);
        check("rst_done", {30'd0, i_done, d_done}, 32'd0);
        check("rst_i_rdata", i_rdata, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        rst = 1'b0;
        tick();

        // Single fetch, one-cycle memory latency
        i_addr = 32'h100; i_req = 1'b1; t0 = cyc;
        do_txn(1, 32'h00500093);
        check("fetch_addr", seen_addr, 32'h100);
        check("fetch_we", {27'd0, seen_we, seen_wstrb}, 32'd0);
        check("fetch_owner", 32'(seen_owner), 32'd0);
        check("fetch_i_done", 32'(i_done), 32'd1);
        check("fetch_d_done", 32'(d_done), 32'd0);
        check("fetch_err", 32'(err), 32'd0);
        check("fetch_rdata", i_rdata, 32'h00500093);
        check("fetch_period", 32'(cyc - t0), 32'd3);
        i_req = 1'b0;
        tick();
        check("fetch_done_pulse", 32'(i_done), 32'd0);
        check("fetch_idle", 32'(busy), 32'd0);

        // Store
        d_we = 1'b1; d_addr = 32'h200; d_wdata = 32'hDEADBEEF; d_wstrb = 4'hF; d_req = 1'b1;
        do_txn(1, 32'h12345678);
        check("st_addr", seen_addr, 32'h200);
        check("st_we", 32'(seen_we), 32'd1);
        check("st_wstrb", 32'(seen_wstrb), 32'hF);
        check("st_wdata", seen_wdata, 32'hDEADBEEF);
        check("st_owner", 32'(seen_owner), 32'd1);
        check("st_done", {30'd0, i_done, d_done}, 32'd1);
        check("st_d_rdata", d_rdata, 32'd0);
        d_req = 1'b0;
        tick();

        // Load: byte enables must not reach memory
        d_we = 1'b0; d_addr = 32'h204; d_wstrb = 4'hF; d_req = 1'b1;
        do_txn(2, 32'h0BADF00D);
        check("ld_wstrb", {27'd0, seen_we, seen_wstrb}, 32'd0);
        check("ld_d_done", 32'(d_done), 32'd1);
        check("ld_d_rdata", d_rdata, 32'h0BADF00D);
        check("ld_i_rdata_kept", i_rdata, 32'h00500093);
        d_req = 1'b0;
        tick();

        // Zero-wait memory, back-to-back fetches
        i_addr = 32'h500; i_req = 1'b1; t0 = cyc;
        do_txn(0, 32'hCAFEF00D);
        t1 = cyc;
        check("zw_latency", 32'(t1 - t0), 32'd2);
        check("zw_rdata", i_rdata, 32'hCAFEF00D);
        check("zw_i_done", 32'(i_done), 32'd1);
        do_txn(0, 32'h13579BDF);
        check("zw_period", 32'(cyc - t1), 32'd3);
        check("zw_rdata2", i_rdata, 32'h13579BDF);
        i_req = 1'b0;
        tick();

        // Contention: both requesters held for 12 transactions
        i_addr = 32'h300; d_addr = 32'h400; d_we = 1'b0; i_req = 1'b1; d_req = 1'b1;
        for (int t = 0; t < 12; t++) begin
            exp_owner = (t % 5 == 4) ? 1'b0 : 1'b1;
            do_txn(1, 32'h1000 + 32'(t));
            check($sformatf("cont_owner%0d", t), 32'(seen_owner), 32'(exp_owner));
            check($sformatf("cont_addr%0d", t), seen_addr, exp_owner ? 32'h400 : 32'h300);
            check($sformatf("cont_done%0d", t), {30'd0, i_done, d_done},
                  exp_owner ? 32'd1 : 32'd2);
            if (exp_owner) check($sformatf("cont_drd%0d", t), d_rdata, 32'h1000 + 32'(t));
            else           check($sformatf("cont_ird%0d", t), i_rdata, 32'h1000 + 32'(t));
        end
        i_req = 1'b0; d_req = 1'b0;
        tick();

        // Response arrives on the very cycle the timeout would fire
        d_addr = 32'h600; d_we = 1'b0; d_req = 1'b1;
        wait_mem_req();
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        repeat (13) tick();
        check("race_pending", {30'd0, busy, d_done}, 32'd2);
        tick();
        mem_rvalid = 1'b1; mem_rdata = 32'h600D600D;
        tick();
        mem_rvalid = 1'b0;
        check("race_done", 32'(d_done), 32'd1);
        check("race_err", 32'(err), 32'd0);
        check("race_rdata", d_rdata, 32'h600D600D);
        d_req = 1'b0;
        tick();

        // Timeout, then a late response in IDLE
        d_addr = 32'h604; d_req = 1'b1;
        wait_mem_req();
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        repeat (14) tick();
        check("tmo_pending", {30'd0, busy, d_done}, 32'd2);
        tick();
        check("tmo_done", {30'd0, i_done, d_done}, 32'd1);
        check("tmo_err", 32'(err), 32'd1);
        check("tmo_rdata", d_rdata, 32'd0);
        check("tmo_mem_req", 32'(mem_req), 32'd0);
        d_req = 1'b0;
        tick();
        mem_rvalid = 1'b1; mem_rdata = 32'h00000BAD;
        tick();
        mem_rvalid = 1'b0;
        check("late_rvalid_done", {29'd0, err, i_done, d_done}, 32'd0);
        check("late_rvalid_rdata", d_rdata, 32'd0);
        check("late_rvalid_busy", 32'(busy), 32'd0);
        $display("txn timeout owner=1 addr=0x00000604 err observed");

        // Reset while waiting for a response
        i_addr = 32'h700; i_req = 1'b1;
        wait_mem_req();
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        check("mrst_busy_before", 32'(busy), 32'd1);
        rst = 1'b1; i_req = 1'b0;
        tick();
        rst = 1'b0;
        check("mrst_mem", {27'd0, mem_req, mem_wstrb}, 32'd0);
        check("mrst_mem_addr", mem_addr, 32'd0);
        check("mrst_flags", {27'd0, mem_we, i_done, d_done, err, busy}, 32'd0);
        check("mrst_i_rdata", i_rdata, 32'd0);
        check("mrst_d_rdata", d_rdata, 32'd0);
        mem_rvalid = 1'b1; mem_rdata = 32'hFFFFFFFF;
        tick();
        mem_rvalid = 1'b0;
        check("mrst_no_done", {30'd0, i_done, d_done}, 32'd0);
        check("mrst_rdata_kept", i_rdata, 32'd0);
        check("mrst_idle", 32'(busy), 32'd0);
        $display("txn reset-abandoned owner=0 addr=0x00000700");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rv32_mem_arbiter.md
Name: rv32_mem_arbiter

Overview:
- Shares one memory port between the RV32I core's instruction-fetch requester (I) and its load/store requester (D).
- One transaction is outstanding at a time.
- Data side has priority, bounded by an anti-starvation streak limit so fetch always progresses.
- A response timeout turns a hung memory into an error completion, which the core raises as an exception.

Parameters:
- XLEN, 32, address/data width.
- MAX_D_STREAK, 4, consecutive D grants allowed while i_req is pending before I is forced to win. Must be ≥ 1.
- TIMEOUT, 16, cycles allowed from REQ entry to completion. 0 disables the timeout.
- TW, 8, width of the timeout counter. Must satisfy TIMEOUT < 2^TW.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- i_req  in  1  fetch request; held until i_done is observed.
- i_addr  in  XLEN  fetch address; stable while i_req is high.
- i_done  out  1  one-cycle fetch completion pulse.
- i_rdata  out  XLEN  fetched word; valid with i_done, held until the next I completion.
- d_req  in  1  data request; held until d_done is observed.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  XLEN  data address.
- d_wdata  in  XLEN  store data.
- d_wstrb  in  4  byte enables for stores.
- d_done  out  1  one-cycle data completion pulse.
- d_rdata  out  XLEN  load data; valid with d_done, held until the next D completion.
- err  out  1  high together with i_done/d_done when the completion was a timeout.
- mem_req  out  1  request to memory.
- mem_we  out  1  write enable.
- mem_addr  out  XLEN  memory address.
- mem_wdata  out  XLEN  write data.
- mem_wstrb  out  4  byte enables; 0 on reads.
- mem_gnt  in  1  memory accepted the request (sampled while mem_req = 1).
- mem_rvalid  in  1  read data valid / write acknowledge.
- mem_rdata  in  XLEN  read data.
- busy  out  1  state != IDLE.
- owner  out  1  current/last owner, 0 = I, 1 = D.

Behaviour:
- All outputs are registered.
- Reset (synchronous, any state, including mid-transaction):
  - state = IDLE.
  - mem_req, mem_we, mem_wstrb, i_done, d_done, err, busy, owner = 0.
  - mem_addr, mem_wdata, i_rdata, d_rdata = 0.
  - streak and timeout counters = 0.
  - Any in-flight memory response is abandoned.
- States: IDLE, REQ, RESP, DONE.
- IDLE:
  - If d_req or i_req is set, arbitrate and latch the winner's addr/we/wdata/wstrb into the mem_* registers; set owner; go to REQ. mem_req = 1 from the next cycle (1-cycle request latency).
  - I wins when: i_req && !d_req, or i_req && streak == MAX_D_STREAK. Otherwise D wins.
  - An I grant is always a read: mem_we = 0, mem_wstrb = 0.
  - mem_rvalid is ignored in IDLE.
- Streak counter:
  - D grant: streak = min(streak + 1, MAX_D_STREAK).
  - I grant: streak = 0.
  - D grant while i_req is low also sets streak = 0.
- REQ:
  - mem_req = 1; mem_* are held stable.
  - mem_gnt && mem_rvalid → DONE (zero-wait memory).
  - mem_gnt only → RESP; mem_req = 0 next cycle.
- RESP:
  - mem_req = 0.
  - On mem_rvalid → DONE.
- Capture on mem_rvalid:
  - Owner I: i_rdata = mem_rdata.
  - Owner D with d_we = 0: d_rdata = mem_rdata.
  - Stores leave d_rdata unchanged.
- Timeout:
  - Counter is cleared on IDLE→REQ and increments every cycle in REQ/RESP.
  - If TIMEOUT ≠ 0 and the counter reaches TIMEOUT − 1 without completion → DONE with err = 1, mem_req = 0, and the owner's rdata set to 0.
  - If mem_rvalid arrives in the same cycle the timeout fires, the normal completion wins and err = 0.
- DONE:
  - Lasts exactly one cycle: owner's done = 1, err as computed, then → IDLE.
  - The other port's done stays 0.
- Requester contract:
  - A requester may deassert req in the cycle after done is seen.
  - req still high in IDLE is treated as a new transaction.
  - Minimum back-to-back transaction period = 4 cycles (IDLE, REQ, RESP, DONE), or 3 cycles with zero-wait memory.
- Simultaneous i_req and d_req with streak < MAX_D_STREAK: D wins. The loser's req is held and re-arbitrated in the next IDLE.

Test Plan:
- Single fetch: i_req at addr 0x100; memory gnt immediately, rvalid 1 cycle later with 0x00500093 → mem_req high 1 cycle at 0x100, i_done pulse with i_rdata = 0x00500093, err = 0, d_done = 0.
- Store: d_req, d_we = 1, addr 0x200, wdata 0xDEADBEEF, wstrb 0xF → mem_we = 1, mem_wstrb = 0xF, d_done after rvalid, d_rdata unchanged (0 after reset).
- Contention: i_req and d_req held continuously for 12 transactions, MAX_D_STREAK = 4 → grant order D,D,D,D,I,D,D,D,D,I,…; no I starvation.
- Timeout: TIMEOUT = 16, gnt given, rvalid never comes → on cycle 16 after REQ entry: d_done = 1, err = 1, d_rdata = 0, then IDLE; a late rvalid in IDLE is ignored.
- Zero-wait memory: gnt and rvalid in the same cycle → DONE directly, 3-cycle transaction period.
- Reset mid-RESP: rst = 1 for one cycle → next cycle all outputs 0, state IDLE; no done pulse is emitted for the abandoned transaction.
